// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared opcodes and state encoding for the UART command sequencer.
// Imported by the sequencer top and by the bench.
package uart_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    BYTES,
    RUN,
    STEP
  } state_t;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-receiver input and instruction-memory write bus
// of the UART command sequencer.
interface uart_cmd_sequencer_if #(
  parameter int BYTE_BITS = 8,
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 8
);

  logic                 rx_done;
  logic [BYTE_BITS-1:0] rx_data;
  logic                 imem_we;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [WORD_BITS-1:0] imem_wdata;

  modport master (
    output rx_done,
    output rx_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_done,
    input  rx_data,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/uart_cmd_sequencer_rx_timeout_counter.sv
// Inter-byte timeout counter for program loads; expired is
// high once TIMEOUT_CYCLES-1 idle cycles have elapsed since a clear.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Decodes UART opcode bytes to load instruction memory
// and to run or single-step the CPU.
module uart_cmd_sequencer
  import uart_dbg_pkg::*;
#(
  parameter int BYTE_BITS      = 8,
  parameter int WORD_BITS      = 32,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  uart_cmd_sequencer_if.slave bus,
  input  logic i_cpu_halted,
  output logic o_cpu_reset,
  output logic o_cpu_enable,
  output logic o_busy,
  output logic o_load_done,
  output logic o_err
);

  localparam int BW = WORD_BITS - BYTE_BITS;

  state_t               state;
  logic [1:0]           byte_idx;
  logic [ADDR_BITS-1:0] word_idx;
  logic [BYTE_BITS-1:0] words_left;
  logic [BW-1:0]        word_buf;

  logic loading;
  logic tmo_clear;
  logic expired;
  logic is_load;
  logic is_cont;
  logic is_step;
  logic is_halt;

  assign loading   = (state == LEN) || (state == BYTES);
  assign tmo_clear = bus.rx_done || !loading;

  assign o_busy      = (state != IDLE);
  assign o_cpu_reset = loading;

  assign is_load = bus.rx_data == BYTE_BITS'(CMD_LOAD);
  assign is_cont = bus.rx_data == BYTE_BITS'(CMD_CONT);
  assign is_step = bus.rx_data == BYTE_BITS'(CMD_STEP);
  assign is_halt = bus.rx_data == BYTE_BITS'(CMD_HALT);

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (tmo_clear),
    .enable (loading),
    .expired(expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      byte_idx       <= '0;
      word_idx       <= '0;
      words_left     <= '0;
      word_buf       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      o_cpu_enable   <= 1'b0;
      o_load_done    <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      o_load_done <= 1'b0;
      o_err       <= 1'b0;
      unique case (state)
        IDLE: begin
          o_cpu_enable <= 1'b0;
          if (bus.rx_done) begin
            unique case (1'b1)
              is_load: state <= LEN;
              is_cont: begin
                state        <= RUN;
                o_cpu_enable <= !i_cpu_halted;
              end
              is_step: begin
                if (i_cpu_halted) begin
                  o_err <= 1'b1;
                end else begin
                  state        <= STEP;
                  o_cpu_enable <= 1'b1;
                end
              end
              default: o_err <= 1'b1;
            endcase
          end
        end
        LEN: begin
          if (bus.rx_done) begin
            if (bus.rx_data == '0) begin
              o_load_done <= 1'b1;
              state       <= IDLE;
            end else begin
              words_left <= bus.rx_data;
              word_idx   <= '0;
              byte_idx   <= '0;
              word_buf   <= '0;
              state      <= BYTES;
            end
          end else if (expired) begin
            o_err <= 1'b1;
            state <= IDLE;
          end
        end
        BYTES: begin
          if (bus.rx_done) begin
            byte_idx <= byte_idx + 2'd1;
            // Bytes shift in from the top so byte 0 ends in [7:0]
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx;
              bus.imem_wdata <= {bus.rx_data, word_buf};
              word_idx       <= word_idx + 1'b1;
              words_left     <= words_left - 1'b1;
              if (words_left == BYTE_BITS'(1)) begin
                o_load_done <= 1'b1;
                state       <= IDLE;
              end
            end else begin
              word_buf <= {bus.rx_data,
                           word_buf[BW-1:BYTE_BITS]};
            end
          end else if (expired) begin
            o_err    <= 1'b1;
            byte_idx <= '0;
            word_buf <= '0;
            state    <= IDLE;
          end
        end
        RUN: begin
          if (i_cpu_halted || (bus.rx_done && is_halt)) begin
            o_cpu_enable <= 1'b0;
            state        <= IDLE;
          end
        end
        STEP: begin
          o_cpu_enable <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: per-cycle vector
// table plus timeout, run/halt and mid-load reset sequences.
module tb_uart_cmd_sequencer;
  import uart_dbg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic halted;
  logic cpu_reset;
  logic cpu_enable;
  logic busy;
  logic load_done;
  logic err;

  always #5 clk = ~clk;

  uart_cmd_sequencer_if #(
    .BYTE_BITS(8),
    .WORD_BITS(32),
    .ADDR_BITS(8)
  ) bus ();

  uart_cmd_sequencer #(
    .BYTE_BITS     (8),
    .WORD_BITS     (32),
    .ADDR_BITS     (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .i_cpu_halted(halted),
    .o_cpu_reset (cpu_reset),
    .o_cpu_enable(cpu_enable),
    .o_busy      (busy),
    .o_load_done (load_done),
    .o_err       (err)
  );

  // {we, cpu_reset, cpu_enable, busy, load_done, err}
  typedef struct {
    logic        rx;
    logic [7:0]  data;
    logic        halt;
    logic [5:0]  exp;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) we_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  function automatic logic [5:0] outs();
    return {bus.imem_we, cpu_reset, cpu_enable,
            busy, load_done, err};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    int we0;
    int err0;

    vecs[0]  = '{1'b1, 8'h4C, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[2]  = '{1'b1, 8'h13, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[3]  = '{1'b1, 8'h00, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[5]  = '{1'b1, 8'h24, 1'b0, 6'b110100, 8'h00,
                 32'h24010013};
    vecs[6]  = '{1'b1, 8'h0A, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[8]  = '{1'b1, 8'h02, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[9]  = '{1'b1, 8'h24, 1'b0, 6'b100010, 8'h01,
                 32'h2402000A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[11] = '{1'b1, 8'h4C, 1'b0, 6'b010100, 8'h00, 32'h0};
    vecs[12] = '{1'b1, 8'h00, 1'b0, 6'b000010, 8'h00, 32'h0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[14] = '{1'b1, 8'h53, 1'b0, 6'b001100, 8'h00, 32'h0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[16] = '{1'b1, 8'h53, 1'b1, 6'b000001, 8'h00, 32'h0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[18] = '{1'b1, 8'h7F, 1'b0, 6'b000001, 8'h00, 32'h0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[20] = '{1'b1, 8'h48, 1'b0, 6'b000001, 8'h00, 32'h0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};
    vecs[22] = '{1'b1, 8'h43, 1'b1, 6'b000100, 8'h00, 32'h0};
    vecs[23] = '{1'b0, 8'h00, 1'b1, 6'b000000, 8'h00, 32'h0};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 6'b000000, 8'h00, 32'h0};

    rst = 1'b1;
    halted = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_addr", 32'(bus.imem_addr), 32'h0);
    chk("reset_wdata", bus.imem_wdata, 32'h0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < NV; i++) begin
      bus.rx_done = vecs[i].rx;
      bus.rx_data = vecs[i].data;
      halted      = vecs[i].halt;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
      chk($sformatf("vec%0d_outs", i),
          32'(outs()), 32'(vecs[i].exp));
      if (vecs[i].exp[5]) begin
        chk($sformatf("vec%0d_addr", i),
            32'(bus.imem_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_wdata", i),
            bus.imem_wdata, vecs[i].wdata);
      end
    end
    halted = 1'b0;

    // Partial load then silence
    we0 = we_cnt;
    send(8'h4C);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    chk("tmo_cpu_reset", 32'(cpu_reset), 32'h1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!err && n < 200);
    chk("tmo_latency", n, 100);
    chk("tmo_outs", 32'(outs()), 32'h01);
    idle(1);
    chk("tmo_idle", 32'(outs()), 32'h0);
    chk("tmo_no_write", we_cnt - we0, 0);

    // Run until halted rises
    send(8'h43);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (cpu_enable) cnt++;
      if (i == 49) halted = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("run_halt_cycles", cnt, 50);
    chk("run_halt_busy", 32'(busy), 32'h0);
    halted = 1'b0;
    idle(1);

    // Run stopped by 'H'; other bytes ignored
    err0 = err_cnt;
    send(8'h43);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (cpu_enable) cnt++;
      bus.rx_done = (i == 29) || (i == 49);
      bus.rx_data = (i == 49) ? 8'h48 : 8'h41;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
    end
    chk("run_h_cycles", cnt, 50);
    chk("run_h_busy", 32'(busy), 32'h0);
    chk("run_h_no_err", err_cnt - err0, 0);

    // Reset in the cycle after the 3rd byte of a word
    we0 = we_cnt;
    send(8'h4C);
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_outs", 32'(outs()), 32'h0);
    idle(5);
    chk("rst_mid_no_write", we_cnt - we0, 0);
    chk("rst_mid_idle", 32'(outs()), 32'h0);

    send(8'h4C);
    send(8'h01);
    send(8'h78);
    send(8'h56);
    send(8'h34);
    send(8'h12);
    chk("reload_outs", 32'(outs()), 32'h22);
    chk("reload_addr", 32'(bus.imem_addr), 32'h0);
    chk("reload_wdata", bus.imem_wdata, 32'h12345678);
    idle(1);
    chk("reload_idle", 32'(outs()), 32'h0);
    chk("reload_one_write", we_cnt - we0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
